// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - FSM state encoding (binary, 3 bits)
//   - default command bytes for operand and operand-reuse frames
//   - default datapath widths and number of bytes per ALU result
package alu_ctrl_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_A   = 3'd1;
    localparam logic [2:0] S_GET_B   = 3'd2;
    localparam logic [2:0] S_GET_FUN = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_SEND_LO = 3'd5;
    localparam logic [2:0] S_SEND_HI = 3'd6;

    localparam logic [7:0] DEF_CMD_ALU_OPS = 8'hCC;
    localparam logic [7:0] DEF_CMD_ALU_NOP = 8'hDD;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int RESULT_BYTES   = DEF_OUT_WIDTH / DEF_DATA_WIDTH;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the byte receive path and the shared ALU.
// Parses CMD_ALU_OPS (cmd, A, B, FUN) and CMD_ALU_NOP (cmd, FUN) frames,
// runs the ALU under a watchdog, and returns the result low byte first.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   RX_P_DATA, RX_D_VLD      received byte + strobe
//   ALU_OUT, ALU_OUT_VALID   ALU result + valid
//   TX_BUSY                  transmitter back-pressure
//   ALU_A, ALU_B, ALU_FUN    latched operands / function
//   ALU_EN, ALU_CLK_EN       ALU enable and clock-gate enable
//   TX_P_DATA, TX_D_VLD      transmit byte + request
//   BUSY                     sequencer not idle
//   ERR                      one-cycle error pulse
// All outputs come straight from flops; the "Moore" outputs are loaded
// from the next-state value so they line up with the state register.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int                    TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPS = DEF_CMD_ALU_OPS,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DEF_CMD_ALU_NOP
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  ALU_CLK_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_nxt;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [3:0]            r_fun;
    logic [WD_W-1:0]       r_wd;
    logic [OUT_WIDTH-1:0]  r_result;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_alu_en;
    logic                  r_tx_vld;
    logic                  r_busy;
    logic                  r_err;

    // Next state and error detection.
    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OPS)      w_nxt = S_GET_A;
                    else if (RX_P_DATA == CMD_ALU_NOP) w_nxt = S_GET_FUN;
                    else                               w_err = 1'b1;
                end
            end
            S_GET_A:   if (RX_D_VLD) w_nxt = S_GET_B;
            S_GET_B:   if (RX_D_VLD) w_nxt = S_GET_FUN;
            S_GET_FUN: if (RX_D_VLD) w_nxt = S_EXEC;
            S_EXEC: begin
                // Overrun byte is dropped; valid takes priority over timeout.
                w_err = RX_D_VLD;
                if (ALU_OUT_VALID) begin
                    w_nxt = S_SEND_LO;
                end else if (r_wd == WD_LAST) begin
                    w_nxt = S_IDLE;
                    w_err = 1'b1;
                end
            end
            S_SEND_LO: begin
                w_err = RX_D_VLD;
                if (!TX_BUSY) w_nxt = S_SEND_HI;
            end
            S_SEND_HI: begin
                w_err = RX_D_VLD;
                if (!TX_BUSY) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_fun     <= '0;
            r_wd      <= '0;
            r_result  <= '0;
            r_tx_data <= '0;
            r_alu_en  <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_alu_en <= (w_nxt == S_EXEC);
            r_tx_vld <= (w_nxt == S_SEND_LO) || (w_nxt == S_SEND_HI);
            r_busy   <= (w_nxt != S_IDLE);
            r_err    <= w_err;

            if (RX_D_VLD) begin
                case (r_state)
                    S_GET_A:   r_a   <= RX_P_DATA;
                    S_GET_B:   r_b   <= RX_P_DATA;
                    S_GET_FUN: r_fun <= RX_P_DATA[3:0];
                    default:   ;
                endcase
            end

            // Watchdog restarts with each FUN byte and counts EXEC cycles.
            if (r_state == S_GET_FUN && RX_D_VLD) r_wd <= '0;
            else if (r_state == S_EXEC)           r_wd <= r_wd + WD_W'(1);

            // Low byte is staged at capture so TX_P_DATA is ready with the
            // request; the high byte is swapped in when the low one is taken.
            if (r_state == S_EXEC && ALU_OUT_VALID) begin
                r_result  <= ALU_OUT;
                r_tx_data <= ALU_OUT[DATA_WIDTH-1:0];
            end else if (r_state == S_SEND_LO && !TX_BUSY) begin
                r_tx_data <= r_result[OUT_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    assign ALU_A      = r_a;
    assign ALU_B      = r_b;
    assign ALU_FUN    = r_fun;
    assign ALU_EN     = r_alu_en;
    assign ALU_CLK_EN = r_alu_en;
    assign TX_P_DATA  = r_tx_data;
    assign TX_D_VLD   = r_tx_vld;
    assign BUSY       = r_busy;
    assign ERR        = r_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames from the test plan followed by
// randomized frames; expected TX bytes go into a queue at frame issue and
// a negedge monitor pops them on every accepted transmit.
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'h0;
    logic        ALU_OUT_VALID = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, ALU_CLK_EN, TX_D_VLD, BUSY, ERR;

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .TX_BUSY(TX_BUSY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_CLK_EN(ALU_CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    int         err_exp = 0, err_seen = 0, tx_cnt = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [3:0] m_fun = 4'h0;
    int         alu_lat = 2;
    bit         rand_busy = 1'b0, forced_busy = 1'b0;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU stand-in: valid one cycle, alu_lat cycles after ALU_EN rises (0 = never).
    int alu_cnt = 0;
    always @(posedge CLK) begin
        if (!ALU_EN) begin
            alu_cnt = 0;
            ALU_OUT_VALID <= 1'b0;
        end else begin
            alu_cnt = alu_cnt + 1;
            ALU_OUT_VALID <= (alu_lat != 0) && (alu_cnt == alu_lat);
        end
        ALU_OUT <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end

    // Sole driver of TX_BUSY, applied after the stimulus updates at +1.
    always begin
        @(posedge CLK);
        #2;
        TX_BUSY = rand_busy ? ($urandom_range(0, 2) == 0) : forced_busy;
    end

    // Monitor: scoreboard pops, ERR counting, back-pressure stability.
    logic [7:0] prev_data = 8'h00;
    bit         prev_hold = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            prev_hold = 1'b0;
        end else begin
            if (ERR) err_seen++;
            if (prev_hold) begin
                chk("tx_hold_vld", 32'(TX_D_VLD), 32'd1);
                chk("tx_hold_data", 32'(TX_P_DATA), 32'(prev_data));
            end
            if (TX_D_VLD && !TX_BUSY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %0h, expected none", TX_P_DATA);
                end else begin
                    chk("tx_byte", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
                end
                tx_cnt++;
            end
            prev_hold = TX_D_VLD && TX_BUSY;
            prev_data = TX_P_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic issue_expect(input int lat);
        logic [15:0] r;
        r = alu_f(m_a, m_b, m_fun);
        if (lat != 0) begin
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
        end else begin
            err_exp++;
        end
    endtask

    task automatic check_exec_entry();
        chk("alu_a", 32'(ALU_A), 32'(m_a));
        chk("alu_b", 32'(ALU_B), 32'(m_b));
        chk("alu_fun", 32'(ALU_FUN), 32'(m_fun));
        chk("alu_en", 32'(ALU_EN), 32'd1);
        chk("alu_clk_en", 32'(ALU_CLK_EN), 32'd1);
        chk("busy_exec", 32'(BUSY), 32'd1);
    endtask

    task automatic frame_ops(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input int lat);
        alu_lat = lat;
        rx(8'hCC);
        rx(a);
        chk("a_latch", 32'(ALU_A), 32'(a));
        rx(b);
        rx(f);
        m_a = a; m_b = b; m_fun = f[3:0];
        check_exec_entry();
        issue_expect(lat);
    endtask

    task automatic frame_nop(input logic [7:0] f, input int lat);
        alu_lat = lat;
        rx(8'hDD);
        rx(f);
        m_fun = f[3:0];
        check_exec_entry();
        issue_expect(lat);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY || exp_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_wait: still busy after %0d cycles, required idle", n);
        end
        tick();
        chk("err_count", 32'(err_seen), 32'(err_exp));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int t0;
        logic [7:0] v;
        int kind;
        int lat;

        // Reset state
        tick();
        tick();
        chk("rst_alu_a", 32'(ALU_A), 0);
        chk("rst_alu_b", 32'(ALU_B), 0);
        chk("rst_alu_fun", 32'(ALU_FUN), 0);
        chk("rst_tx_data", 32'(TX_P_DATA), 0);
        chk("rst_alu_en", 32'(ALU_EN), 0);
        chk("rst_alu_clk_en", 32'(ALU_CLK_EN), 0);
        chk("rst_tx_vld", 32'(TX_D_VLD), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_err", 32'(ERR), 0);
        RST = 1'b0;
        tick();

        // Add: 0x12 + 0x34
        frame_ops(8'h12, 8'h34, 8'h00, 2);
        wait_idle();
        chk("add_busy_after", 32'(BUSY), 0);

        // Multiply, then reuse operands with subtract
        frame_ops(8'hFF, 8'h02, 8'h02, 2);
        wait_idle();
        frame_nop(8'h01, 2);
        wait_idle();

        // Timeout: ERR 15 cycles after EXEC entry, nothing sent
        t0 = tx_cnt;
        alu_lat = 0;
        rx(8'hCC); rx(8'h01); rx(8'h01); rx(8'h00);
        m_a = 8'h01; m_b = 8'h01; m_fun = 4'h0;
        err_exp++;
        n = 0;
        while (!ERR && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_err_cycle", 32'(n), 32'd15);
        chk("timeout_alu_en", 32'(ALU_EN), 0);
        chk("timeout_busy", 32'(BUSY), 0);
        chk("timeout_tx_vld", 32'(TX_D_VLD), 0);
        wait_idle();
        chk("timeout_no_tx", 32'(tx_cnt - t0), 0);

        // Back-pressure on the low byte for 5 cycles
        t0 = tx_cnt;
        forced_busy = 1'b1;
        frame_ops(8'h21, 8'h43, 8'h00, 2);
        n = 0;
        while (!TX_D_VLD && n < 40) begin
            tick();
            n++;
        end
        chk("bp_vld_seen", 32'(TX_D_VLD), 1);
        repeat (5) tick();
        chk("bp_vld_held", 32'(TX_D_VLD), 1);
        chk("bp_data_held", 32'(TX_P_DATA), 32'h64);
        forced_busy = 1'b0;
        wait_idle();
        chk("bp_tx_once", 32'(tx_cnt - t0), 2);

        // Bad command in IDLE
        rx(8'hAB);
        err_exp++;
        chk("bad_cmd_err", 32'(ERR), 1);
        chk("bad_cmd_busy", 32'(BUSY), 0);
        wait_idle();

        // Overrun during EXEC
        frame_ops(8'h05, 8'h03, 8'h01, 4);
        rx(8'hCC);
        err_exp++;
        wait_idle();

        // Reset mid-frame
        alu_lat = 2;
        rx(8'hCC);
        rx(8'h12);
        RST = 1'b1;
        #1;
        chk("mid_rst_alu_a", 32'(ALU_A), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_alu_en", 32'(ALU_EN), 0);
        chk("mid_rst_tx_vld", 32'(TX_D_VLD), 0);
        chk("mid_rst_err", 32'(ERR), 0);
        tick();
        RST = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
        tick();
        frame_nop(8'h00, 2);
        wait_idle();

        // Randomized frames with random back-pressure
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            lat  = $urandom_range(1, 6);
            if (kind == 0) begin
                do v = 8'($urandom_range(0, 255)); while (v == 8'hCC || v == 8'hDD);
                rx(v);
                err_exp++;
            end else begin
                if (kind == 9) lat = 0;
                if (kind <= 5)
                    frame_ops(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), lat);
                else
                    frame_nop(8'($urandom_range(0, 255)), lat);
                if ($urandom_range(0, 3) == 0) begin
                    rx(8'($urandom_range(0, 255)));
                    err_exp++;
                end
            end
            wait_idle();
        end
        rand_busy = 1'b0;
        tick();

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_err_count", 32'(err_seen), 32'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
